// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device command transmitter.
// Frame layout helper: start(0), data LSB first, odd parity, stop(1).
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_DATA,
    ST_ACK,
    ST_DONE,
    ST_ERR
  } ps2_state_e;

  localparam int FRAME_BITS = 11;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-stage synchroniser for an asynchronous PS/2 pin, with a falling-edge
// pulse derived from the synchronised level. Lines idle high, so reset to 1.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic fe_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign fe_o    = prev_q & ~level_o;

endmodule

// File: rtl/ps2_cmd_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, device-clocked
// frame, ACK check. Optional response timeout enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_cmd_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  output ps2_state_e dbg_state
);

  // Handshake: a command is taken on any cycle where cmd_valid & cmd_ready; cmd_ready
  // is high only in IDLE, and cmd_valid seen at any other time is simply dropped.

  localparam int             INH_W    = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [3:0]     STOP_IDX = 4'(FRAME_BITS - 1);

  ps2_state_e               state_q, state_d;
  logic [INH_W-1:0]         inh_cnt_q, inh_cnt_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]    frame_q, frame_d;
  logic [1:0]               err_code_q, err_code_d;

  logic clk_level, clk_fe, dat_level, dat_fe_unused;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .pin_i(ps2_clk_in), .level_o(clk_level), .fe_o(clk_fe)
  );

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(clk), .rst_n(rst_n), .pin_i(ps2_dat_in), .level_o(dat_level), .fe_o(dat_fe_unused)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inh_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      frame_q    <= '1;
      err_code_q <= ERR_NONE;
    end else begin
      inh_cnt_q  <= inh_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    err_code_d = err_code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          frame_d    = make_frame(cmd_data);
          err_code_d = ERR_NONE;
          inh_cnt_d  = '0;
          state_d    = ST_INHIBIT;
        end
      end
      // Falling edges here come from our own pulldown and are ignored.
      ST_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) state_d = ST_RTS;
        else                       inh_cnt_d = inh_cnt_q + 1'b1;
      end
      ST_RTS: begin
        bit_cnt_d = '0;
        state_d   = ST_DATA;
      end
      ST_DATA: begin
        if (clk_fe) begin
          if (bit_cnt_q == STOP_IDX) begin
            if (dat_level) begin
              state_d    = ST_ERR;
              err_code_d = ERR_NACK;
            end else begin
              state_d = ST_ACK;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_ACK:  if (clk_level && dat_level) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    to_cnt_d = '0;
    if (state_q inside {ST_RTS, ST_DATA, ST_ACK}) begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (to_cnt_q == TO_LAST) begin
        state_d    = ST_ERR;
        err_code_d = ERR_TIMEOUT;
      end
    end
`endif
  end

  always_comb begin
    cmd_ready  = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    tx_busy    = 1'b0;
    tx_done    = 1'b0;
    tx_err     = 1'b0;
    unique case (state_q)
      ST_IDLE:    cmd_ready = 1'b1;
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = (inh_cnt_q == INH_LAST);
        tx_busy    = 1'b1;
      end
      ST_RTS: begin
        ps2_dat_oe = 1'b1;
        tx_busy    = 1'b1;
      end
      // bit_cnt 0 holds the start bit; each device falling edge advances one bit.
      ST_DATA: begin
        ps2_dat_oe = ~frame_q[bit_cnt_q];
        tx_busy    = 1'b1;
      end
      ST_ACK:  tx_busy = 1'b1;
      ST_DONE: tx_done = 1'b1;
      ST_ERR:  tx_err  = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  assign err_code  = err_code_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ps2_cmd_tx.sv
// Bench for ps2_cmd_tx: open-drain pins plus a PS/2 device model clocking at 40 clk
// cycles per bit; expected frame bits are queued at accept and popped as the device samples.
module tb_ps2_cmd_tx;

  localparam int INH = 5000;
  localparam int HALF = 20;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_CYC = 2000;
`else
  localparam int TO_CYC = 750000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic [2:0] dbg_state;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       pin_clk, pin_dat;

  assign pin_clk = ~(ps2_clk_oe | dev_clk_low);
  assign pin_dat = ~(ps2_dat_oe | dev_dat_low);

  ps2_cmd_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO_CYC), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .ps2_clk_in(pin_clk), .ps2_dat_in(pin_dat),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_err(tx_err), .err_code(err_code), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #(10 * 400000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic done_prev = 1'b0;
  logic err_prev  = 1'b0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // pulse monitor: counts completions and checks the cycle after each pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_prev) check("ready_after_done", {31'd0, cmd_ready}, 1);
      if (err_prev)  check("ready_after_err", {31'd0, cmd_ready}, 1);
      if (tx_done) done_cnt++;
      if (tx_err)  err_cnt++;
    end
    done_prev = tx_done;
    err_prev  = tx_err;
  end

  task automatic accept(input logic [7:0] b);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("ready_before_send", {31'd0, cmd_ready}, 1);
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic send_frame(input logic [7:0] b, input bit nack, input int abort_at, input bit inject);
    int n, inh, both, d0, e0;
    logic [0:0] e;
    d0 = done_cnt;
    e0 = err_cnt;
    accept(b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(~^b);
    exp_q.push_back(1'b1);
    check("busy_after_accept", {31'd0, tx_busy}, 1);
    check("err_code_cleared", {30'd0, err_code}, 0);
    inh = 0;
    both = 0;
    while (ps2_clk_oe && inh < 2 * INH) begin
      inh++;
      if (ps2_dat_oe) both++;
      @(negedge clk);
    end
    check("inhibit_len", inh, INH);
    check("inhibit_dat_overlap", both, 1);
    check("rts_dat_oe", {31'd0, ps2_dat_oe}, 1);
    e = exp_q.pop_front();
    check("start_bit", {31'd0, pin_dat}, {31'd0, e});
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_clk_oe", {31'd0, ps2_clk_oe}, 0);
        check("abort_dat_oe", {31'd0, ps2_dat_oe}, 0);
        check("abort_busy", {31'd0, tx_busy}, 0);
        check("abort_ready", {31'd0, cmd_ready}, 1);
        dev_clk_low = 1'b0;
        rst_n = 1'b1;
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_err", err_cnt - e0, 0);
        return;
      end
      e = exp_q.pop_front();
      check($sformatf("frame_bit%0d", k), {31'd0, pin_dat}, {31'd0, e});
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      if (inject && k == 3) begin
        cmd_data  = 8'h55;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("ignored_ready", {31'd0, cmd_ready}, 0);
        cmd_valid = 1'b0;
      end
    end
    // ACK clock: device pulls DAT low (or not, for a NACK) and clocks once more
    dev_dat_low = ~nack;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_dat_low = 1'b0;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("done_pulses", done_cnt - d0, nack ? 0 : 1);
    check("err_pulses", err_cnt - e0, nack ? 1 : 0);
    check("err_code", {30'd0, err_code}, nack ? 1 : 0);
    check("clk_oe_idle", {31'd0, ps2_clk_oe}, 0);
    check("dat_oe_idle", {31'd0, ps2_dat_oe}, 0);
    check("busy_idle", {31'd0, tx_busy}, 0);
  endtask

`ifdef PS2_TX_TIMEOUT_EN
  task automatic timeout_case();
    int n, d0;
    d0 = done_cnt;
    accept(8'h12);
    n = 0;
    while (ps2_clk_oe && n < 2 * INH) begin @(negedge clk); n++; end
    n = 0;
    while (!tx_err && n < 3 * TO_CYC) begin @(negedge clk); n++; end
    check("timeout_cycles", n, TO_CYC);
    check("timeout_code", {30'd0, err_code}, 2);
    check("timeout_dat_oe", {31'd0, ps2_dat_oe}, 0);
    check("timeout_clk_oe", {31'd0, ps2_clk_oe}, 0);
    repeat (3) @(negedge clk);
    check("timeout_no_done", done_cnt - d0, 0);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 1);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("rst_dat_oe", {31'd0, ps2_dat_oe}, 0);
    check("rst_busy", {31'd0, tx_busy}, 0);
    check("rst_done", {31'd0, tx_done}, 0);
    check("rst_err", {31'd0, tx_err}, 0);
    check("rst_err_code", {30'd0, err_code}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'hED, 1'b0, 0, 1'b0);
    send_frame(8'h01, 1'b0, 0, 1'b0);
    send_frame(8'hFF, 1'b0, 0, 1'b0);
    send_frame(8'h3C, 1'b1, 0, 1'b0);
    send_frame(8'hA6, 1'b0, 0, 1'b1);
    send_frame(8'h9B, 1'b0, 5, 1'b0);
    send_frame(8'hF4, 1'b0, 0, 1'b0);
`ifdef PS2_TX_TIMEOUT_EN
    timeout_case();
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
